// File: rtl/mem_load_unit_pkg.sv
// Shared constants and types for the LEGv8 MEM-stage load engine.
package mem_load_unit_pkg;

  localparam int unsigned WORD       = 64;
  localparam int unsigned MLU_ADDR_W = 64;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ0  = 3'd1;
  localparam logic [2:0] ST_WAIT0 = 3'd2;
  localparam logic [2:0] ST_REQ1  = 3'd3;
  localparam logic [2:0] ST_WAIT1 = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef struct packed {
    logic [2:0] offset;
    logic [1:0] size;
    logic       sign_ext;
  } load_req_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    return 4'(1) << sz;
  endfunction

endpackage

// File: rtl/mem_load_unit_if.sv
// Data-memory read interface: one outstanding request, valid/ready request, valid response.
interface mem_load_unit_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 64
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  modport master (
    output mem_req_valid,
    output mem_addr,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_addr,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_data
  );
endinterface

// File: rtl/mem_load_unit_load_align.sv
// Extracts the addressed field from two little-endian beats and sign/zero extends it.
module load_align
  import mem_load_unit_pkg::*;
(
  input  logic [2*WORD-1:0] i_beats,
  input  logic [2:0]        i_offset,
  input  logic [1:0]        i_size,
  input  logic              i_sign_ext,
  output logic [WORD-1:0]   o_data
);

  logic [WORD-1:0] w_field;

  assign w_field = WORD'(i_beats >> {i_offset, 3'b000});

  always_comb begin
    o_data = w_field;
    case (i_size)
      SZ_B:    o_data = {{(WORD-8){i_sign_ext & w_field[7]}},   w_field[7:0]};
      SZ_H:    o_data = {{(WORD-16){i_sign_ext & w_field[15]}}, w_field[15:0]};
      SZ_W:    o_data = {{(WORD-32){i_sign_ext & w_field[31]}}, w_field[31:0]};
      default: o_data = w_field;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// MEM-stage load engine: issues one or two aligned beat reads per load and returns the extended result.
module mem_load_unit
  import mem_load_unit_pkg::*;
#(
  parameter int unsigned DATA_W = WORD,
  parameter int unsigned ADDR_W = MLU_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [1:0]         size,
  input  logic               sign_ext,
  output logic               stall,
  mem_load_unit_if.master    mem,
  output logic [DATA_W-1:0]  r_data,
  output logic               r_data_valid
);

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  load_req_t         r_req;
  logic              r_split;
  logic [DATA_W-1:0] r_beat0;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              w_split;
  logic [DATA_W-1:0] w_beat_lo;
  logic [DATA_W-1:0] w_beat_hi;
  logic [DATA_W-1:0] w_aligned;

  assign w_split = ({1'b0, addr[2:0]} + size_bytes(size)) > 4'd8;

  // The beat arriving this cycle feeds the aligner directly so r_data is ready in DONE.
  assign w_beat_lo = (r_state == ST_WAIT1) ? r_beat0 : mem.mem_resp_data;
  assign w_beat_hi = (r_state == ST_WAIT1) ? mem.mem_resp_data : '0;

  load_align u_load_align (
    .i_beats    ({w_beat_hi, w_beat_lo}),
    .i_offset   (r_req.offset),
    .i_size     (r_req.size),
    .i_sign_ext (r_req.sign_ext),
    .o_data     (w_aligned)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state      = r_state;
    stall             = 1'b0;
    mem.mem_req_valid = 1'b0;
    mem.mem_addr      = r_mem_addr;
    case (r_state)
      ST_IDLE: begin
        stall = req_valid;
        if (req_valid) w_next_state = ST_REQ0;
      end
      ST_REQ0: begin
        stall             = 1'b1;
        mem.mem_req_valid = 1'b1;
        if (mem.mem_req_ready) w_next_state = ST_WAIT0;
      end
      ST_WAIT0: begin
        stall = 1'b1;
        if (mem.mem_resp_valid) w_next_state = r_split ? ST_REQ1 : ST_DONE;
      end
      ST_REQ1: begin
        stall             = 1'b1;
        mem.mem_req_valid = 1'b1;
        if (mem.mem_req_ready) w_next_state = ST_WAIT1;
      end
      ST_WAIT1: begin
        stall = 1'b1;
        if (mem.mem_resp_valid) w_next_state = ST_DONE;
      end
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req        <= '0;
      r_split      <= 1'b0;
      r_beat0      <= '0;
      r_mem_addr   <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_req      <= '{offset: addr[2:0], size: size, sign_ext: sign_ext};
            r_split    <= w_split;
            r_mem_addr <= {addr[ADDR_W-1:3], 3'b000};
          end
        end
        ST_WAIT0: begin
          if (mem.mem_resp_valid) begin
            r_beat0 <= mem.mem_resp_data;
            if (r_split) begin
              r_mem_addr <= r_mem_addr + ADDR_W'(8);
            end else begin
              r_data       <= w_aligned;
              r_data_valid <= 1'b1;
            end
          end
        end
        ST_WAIT1: begin
          if (mem.mem_resp_valid) begin
            r_data       <= w_aligned;
            r_data_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed bench for mem_load_unit with a single-outstanding memory responder driven per cycle.
module tb_mem_load_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [63:0] addr;
  logic [1:0]  size;
  logic        sign_ext;
  logic        stall;
  logic [63:0] r_data;
  logic        r_data_valid;

  int n_tests = 0;
  int n_fail  = 0;

  mem_load_unit_if mif ();

  mem_load_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .addr         (addr),
    .size         (size),
    .sign_ext     (sign_ext),
    .stall        (stall),
    .mem          (mif),
    .r_data       (r_data),
    .r_data_valid (r_data_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_read(input logic [63:0] a);
    if (a == 64'h100)      return 64'h8877665544332211;
    else if (a == 64'h108) return 64'hFFEEDDCCBBAA9988;
    else                   return ~a;
  endfunction

  // Issues one load in cycle 0 and services memory until r_data_valid or the cycle budget runs out.
  task automatic run_load(input logic [63:0] a, input logic [1:0] sz, input logic se,
                          input int ready_low, output int valid_cyc, output logic [63:0] data,
                          output int nreq, output logic [63:0] ra0, output logic [63:0] ra1,
                          output int stall_cyc, output int rv_cyc, output bit addr_stable);
    bit          pend = 0;
    logic [63:0] pend_addr = '0;
    logic [63:0] first_addr = '0;
    bit          seen_req = 0;
    int          low_left = ready_low;
    valid_cyc = -1; data = '0; nreq = 0; ra0 = '0; ra1 = '0;
    stall_cyc = 0; rv_cyc = 0; addr_stable = 1;
    for (int cyc = 0; cyc < 40 && valid_cyc < 0; cyc++) begin
      @(negedge clk);
      req_valid          = (cyc == 0);
      addr               = a;
      size               = sz;
      sign_ext           = se;
      mif.mem_resp_valid = pend;
      mif.mem_resp_data  = pend ? mem_read(pend_addr) : 64'hDEADBEEFCAFEF00D;
      mif.mem_req_ready  = (low_left == 0);
      #1;
      if (stall) stall_cyc++;
      if (r_data_valid) begin
        valid_cyc = cyc;
        data      = r_data;
      end
      pend = 0;
      if (mif.mem_req_valid) begin
        rv_cyc++;
        if (!seen_req) begin
          first_addr = mif.mem_addr;
          seen_req   = 1;
        end else if (nreq == 0 && mif.mem_addr !== first_addr) begin
          addr_stable = 0;
        end
        if (mif.mem_req_ready) begin
          if (nreq == 0) ra0 = mif.mem_addr;
          else           ra1 = mif.mem_addr;
          nreq++;
          pend      = 1;
          pend_addr = mif.mem_addr;
        end else begin
          low_left--;
        end
      end
    end
    @(negedge clk);
    req_valid          = 0;
    mif.mem_resp_valid = 0;
    mif.mem_req_ready  = 1;
  endtask

  task automatic test_reset;
    bit bad = 0;
    rst = 1; req_valid = 0; addr = '0; size = '0; sign_ext = 0;
    mif.mem_req_ready = 1; mif.mem_resp_valid = 0; mif.mem_resp_data = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
    n_tests++; if (mif.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req_valid got %b want 0", mif.mem_req_valid); end
    n_tests++; if (mif.mem_addr !== 64'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", mif.mem_addr); end
    n_tests++; if (r_data !== 64'h0 || r_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_r_data got %h/%b want 0/0", r_data, r_data_valid); end
    // Stray responses while idle must be ignored.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mif.mem_resp_valid = 1; mif.mem_resp_data = 64'h1234;
      #1;
      if (r_data_valid !== 1'b0 || stall !== 1'b0 || mif.mem_req_valid !== 1'b0) bad = 1;
    end
    @(negedge clk); mif.mem_resp_valid = 0;
    #1;
    n_tests++; if (bad || r_data !== 64'h0) begin n_fail++; $display("FAIL stray_resp got bad=%0d r_data=%h want 0/0", bad, r_data); end
  endtask

  task automatic test_aligned_dword;
    int vc, nr, sc, rc; logic [63:0] d, a0, a1; bit st;
    run_load(64'h100, 2'd3, 1'b0, 0, vc, d, nr, a0, a1, sc, rc, st);
    n_tests++; if (d !== 64'h8877665544332211) begin n_fail++; $display("FAIL dword_data got %h want 8877665544332211", d); end
    n_tests++; if (vc !== 3) begin n_fail++; $display("FAIL dword_latency got %0d want 3", vc); end
    n_tests++; if (nr !== 1 || a0 !== 64'h100) begin n_fail++; $display("FAIL dword_req got n=%0d a=%h want 1/100", nr, a0); end
    n_tests++; if (sc !== 3) begin n_fail++; $display("FAIL dword_stall_cycles got %0d want 3", sc); end
  endtask

  task automatic test_byte_half_word;
    int vc, nr, sc, rc; logic [63:0] d, a0, a1; bit st;
    run_load(64'h107, 2'd0, 1'b1, 0, vc, d, nr, a0, a1, sc, rc, st);
    n_tests++; if (d !== 64'hFFFFFFFFFFFFFF88) begin n_fail++; $display("FAIL byte_sext got %h want FFFFFFFFFFFFFF88", d); end
    run_load(64'h107, 2'd0, 1'b0, 0, vc, d, nr, a0, a1, sc, rc, st);
    n_tests++; if (d !== 64'h0000000000000088) begin n_fail++; $display("FAIL byte_zext got %h want 88", d); end
    run_load(64'h104, 2'd2, 1'b1, 0, vc, d, nr, a0, a1, sc, rc, st);
    n_tests++; if (d !== 64'hFFFFFFFF88776655) begin n_fail++; $display("FAIL ldursw got %h want FFFFFFFF88776655", d); end
    n_tests++; if (nr !== 1 || vc !== 3) begin n_fail++; $display("FAIL ldursw_single_beat got n=%0d lat=%0d want 1/3", nr, vc); end
    run_load(64'h106, 2'd1, 1'b0, 0, vc, d, nr, a0, a1, sc, rc, st);
    n_tests++; if (d !== 64'h0000000000008877) begin n_fail++; $display("FAIL half_zext got %h want 8877", d); end
  endtask

  task automatic test_split;
    int vc, nr, sc, rc; logic [63:0] d, a0, a1; bit st;
    run_load(64'h105, 2'd3, 1'b0, 0, vc, d, nr, a0, a1, sc, rc, st);
    n_tests++; if (d !== 64'hCCBBAA9988887766) begin n_fail++; $display("FAIL split_dword got %h want CCBBAA9988887766", d); end
    n_tests++; if (nr !== 2 || a0 !== 64'h100 || a1 !== 64'h108) begin n_fail++; $display("FAIL split_reqs got n=%0d %h %h want 2 100 108", nr, a0, a1); end
    n_tests++; if (vc !== 5 || sc !== 5) begin n_fail++; $display("FAIL split_latency got lat=%0d stall=%0d want 5/5", vc, sc); end
    run_load(64'h107, 2'd1, 1'b1, 0, vc, d, nr, a0, a1, sc, rc, st);
    n_tests++; if (d !== 64'hFFFFFFFFFFFF8888 || nr !== 2) begin n_fail++; $display("FAIL split_half got %h n=%0d want FFFFFFFFFFFF8888 2", d, nr); end
    run_load(64'hFFFFFFFFFFFFFFFC, 2'd3, 1'b0, 0, vc, d, nr, a0, a1, sc, rc, st);
    n_tests++; if (a0 !== 64'hFFFFFFFFFFFFFFF8 || a1 !== 64'h0) begin n_fail++; $display("FAIL wrap_addr got %h %h want FFFFFFFFFFFFFFF8 0", a0, a1); end
    n_tests++; if (d !== 64'hFFFFFFFF00000000) begin n_fail++; $display("FAIL wrap_data got %h want FFFFFFFF00000000", d); end
  endtask

  task automatic test_backpressure;
    int vc, nr, sc, rc; logic [63:0] d, a0, a1; bit st;
    run_load(64'h100, 2'd3, 1'b0, 4, vc, d, nr, a0, a1, sc, rc, st);
    n_tests++; if (vc !== 7) begin n_fail++; $display("FAIL bp_latency got %0d want 7", vc); end
    n_tests++; if (rc !== 5 || !st || a0 !== 64'h100) begin n_fail++; $display("FAIL bp_req_hold got valid_cycles=%0d stable=%0d a=%h want 5/1/100", rc, st, a0); end
    n_tests++; if (sc !== 7 || d !== 64'h8877665544332211) begin n_fail++; $display("FAIL bp_stall_data got stall=%0d d=%h want 7 8877665544332211", sc, d); end
  endtask

  task automatic test_back_to_back;
    int vc, nr, sc, rc; logic [63:0] d, a0, a1; bit st;
    run_load(64'h108, 2'd2, 1'b1, 0, vc, d, nr, a0, a1, sc, rc, st);
    n_tests++; if (d !== 64'hFFFFFFFFBBAA9988 || vc !== 3) begin n_fail++; $display("FAIL b2b_first got %h lat=%0d want FFFFFFFFBBAA9988 3", d, vc); end
    run_load(64'h10C, 2'd2, 1'b0, 0, vc, d, nr, a0, a1, sc, rc, st);
    n_tests++; if (d !== 64'h00000000FFEEDDCC || a0 !== 64'h108) begin n_fail++; $display("FAIL b2b_second got %h a=%h want FFEEDDCC 108", d, a0); end
  endtask

  task automatic test_reset_mid_op;
    bit bad = 0;
    @(negedge clk);
    req_valid = 1; addr = 64'h100; size = 2'd3; sign_ext = 0;
    mif.mem_req_ready = 1; mif.mem_resp_valid = 0;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    rst = 1;
    #1;
    n_tests++; if (stall !== 1'b1 || r_data === 64'h0) begin n_fail++; $display("FAIL pre_reset_wait0 got stall=%b r_data=%h want 1/nonzero", stall, r_data); end
    @(negedge clk);
    rst = 0;
    #1;
    n_tests++; if (stall !== 1'b0 || mif.mem_req_valid !== 1'b0 || r_data !== 64'h0) begin n_fail++; $display("FAIL reset_mid_op got stall=%b mrv=%b r_data=%h want 0/0/0", stall, mif.mem_req_valid, r_data); end
    @(negedge clk);
    mif.mem_resp_valid = 1; mif.mem_resp_data = 64'h8877665544332211;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (r_data_valid !== 1'b0 || stall !== 1'b0 || r_data !== 64'h0) bad = 1;
      @(negedge clk);
      mif.mem_resp_valid = 0;
    end
    n_tests++; if (bad) begin n_fail++; $display("FAIL late_resp_after_reset got activity=%0d want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_aligned_dword();
    test_byte_half_word();
    test_split();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
